// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: EX forwarding, load-use stall,
// branch flush, multi-cycle EX FSM and a saturating stall counter.
module hazard_ctrl #(
  parameter int REG_AW = 5,
  parameter int MC_LAT = 4,
  parameter int SCNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] Rs1D,
  input  logic [REG_AW-1:0] Rs2D,
  input  logic [REG_AW-1:0] Rs1E,
  input  logic [REG_AW-1:0] Rs2E,
  input  logic [REG_AW-1:0] RdE,
  input  logic [REG_AW-1:0] RdM,
  input  logic [REG_AW-1:0] RdW,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              LoadE,
  input  logic              MultiCycE,
  input  logic              PCSrcE,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushM,
  output logic              McBusy,
  output logic [SCNT_W-1:0] StallCnt
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam int CW = (MC_LAT > 2) ? $clog2(MC_LAT) : 1;
  localparam logic MC_EN = (MC_LAT > 1);
  localparam logic [CW-1:0] CNT_INIT =
    (MC_LAT > 1) ? CW'(MC_LAT - 2) : '0;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CW-1:0]     r_cnt;
  logic [CW-1:0]     w_cnt_nxt;
  logic [SCNT_W-1:0] r_scnt;
  logic              w_mc_stall;
  logic              w_lw_stall;
  logic              w_br_taken;
  logic              w_stall_fd;
  logic              w_mem_a;
  logic              w_wb_a;
  logic              w_mem_b;
  logic              w_wb_b;

  assign w_mem_a = RegWriteM && (RdM != '0) && (RdM == Rs1E);
  assign w_wb_a  = RegWriteW && (RdW != '0) && (RdW == Rs1E);
  assign w_mem_b = RegWriteM && (RdM != '0) && (RdM == Rs2E);
  assign w_wb_b  = RegWriteW && (RdW != '0) && (RdW == Rs2E);

  // Operand A select, MEM result beats WB result
  always_comb begin
    ForwardAE = 2'b00;
    priority case (1'b1)
      w_mem_a: ForwardAE = 2'b10;
      w_wb_a:  ForwardAE = 2'b01;
      default: ForwardAE = 2'b00;
    endcase
  end

  // Operand B select, same priority as A
  always_comb begin
    ForwardBE = 2'b00;
    priority case (1'b1)
      w_mem_b: ForwardBE = 2'b10;
      w_wb_b:  ForwardBE = 2'b01;
      default: ForwardBE = 2'b00;
    endcase
  end

  assign w_lw_stall = LoadE && (RdE != '0) &&
                      ((RdE == Rs1D) || (RdE == Rs2D));

  // Multi-cycle FSM next state; a taken branch kills the op in IDLE
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_mc_stall  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (MultiCycE && !PCSrcE && MC_EN) begin
          w_state_nxt = BUSY;
          w_cnt_nxt   = CNT_INIT;
          w_mc_stall  = 1'b1;
        end
      end
      BUSY: begin
        if (r_cnt != '0) begin
          w_cnt_nxt  = r_cnt - CW'(1);
          w_mc_stall = 1'b1;
        end else begin
          w_state_nxt = IDLE;
        end
      end
    endcase
  end

  // FSM state and remaining-cycle counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign McBusy     = (r_state == BUSY);
  assign w_br_taken = PCSrcE && !McBusy;
  assign w_stall_fd = w_lw_stall || w_mc_stall;

  assign StallF = w_stall_fd;
  assign StallD = w_stall_fd;
  assign StallE = w_mc_stall;
  assign FlushD = w_br_taken;
  assign FlushE = w_br_taken || (w_lw_stall && !w_mc_stall);
  assign FlushM = w_mc_stall;

  // Stall-cycle counter, sticks at all-ones
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_scnt <= '0;
    end else if (w_stall_fd && (r_scnt != '1)) begin
      r_scnt <= r_scnt + SCNT_W'(1);
    end
  end

  assign StallCnt = r_scnt;

endmodule
